// File: rtl/tinychip_pkg.sv
// Shared types and constants for the TinyChip core: run-control state encoding and
// default datapath widths used by the program sequencer.
package tinychip_pkg;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_LUT_W = 5;
  localparam int SEQ_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    MEM_WAIT = 3'd3,
    DONE     = 3'd4
  } seq_state_e;

endpackage

// File: rtl/program_sequencer_jump_lut.sv
// Programmable branch-target table: 2**LUT_W x PC_W register file with one synchronous
// write port and one combinational read port. Contents are deliberately not reset.
module jump_lut #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [LUT_W-1:0] wr_idx,
  input  logic [PC_W-1:0]  wr_data,
  input  logic [LUT_W-1:0] rd_idx,
  output logic [PC_W-1:0]  rd_data
);

  logic [PC_W-1:0] mem_r [0:(1 << LUT_W)-1];

  // Capture a branch target on a qualified write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/program_sequencer.sv
// Run-control FSM for the TinyChip core: PC, FETCH/EXEC stepping, data-memory stalls with
// timeout, LUT-resolved branches and done/err. Optional macro SEQ_CYCLE_CNT_EN adds the cycle counter.
module program_sequencer
  import tinychip_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int LUT_W    = DEF_LUT_W,
  parameter int START_PC = 0,
  parameter int MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 br_en,
  input  logic [LUT_W-1:0]     br_idx,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  input  logic                 lut_wr_en,
  input  logic [LUT_W-1:0]     lut_wr_idx,
  input  logic [PC_W-1:0]      lut_wr_data,
  output logic [PC_W-1:0]      pc,
  output logic                 instr_valid,
  output logic                 exec_en,
  output logic                 done,
  output logic                 err,
  output logic [SEQ_CNT_W-1:0] cycle_count
);

  localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_ZERO  = {WAIT_W{1'b0}};
  localparam logic [PC_W-1:0]   PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]   START_PC_V = PC_W'(START_PC);

  seq_state_e        state_r;
  logic [PC_W-1:0]   pc_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              instr_valid_r;
  logic              done_r;
  logic              err_r;

  logic [PC_W-1:0]   lut_rd_s;
  logic [PC_W-1:0]   pc_next_s;
  logic [WAIT_W-1:0] wait_inc_s;
  logic              commit_s;
  logic              start_ok_s;
  logic              lut_we_s;

  jump_lut #(
    .PC_W  (PC_W),
    .LUT_W (LUT_W)
  ) u_jump_lut (
    .clk     (clk),
    .wr_en   (lut_we_s),
    .wr_idx  (lut_wr_idx),
    .wr_data (lut_wr_data),
    .rd_idx  (br_idx),
    .rd_data (lut_rd_s)
  );

  // Decode commit, start acceptance, LUT write gating and the next PC
  always_comb begin
    commit_s   = 1'b0;
    start_ok_s = 1'b0;
    lut_we_s   = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        start_ok_s = start;
        lut_we_s   = lut_wr_en;
      end
      EXEC:     commit_s = ~halt & ~mem_req;
      MEM_WAIT: commit_s = mem_ack;
      default: begin
        commit_s   = 1'b0;
        start_ok_s = 1'b0;
        lut_we_s   = 1'b0;
      end
    endcase
    if (br_en) begin
      pc_next_s = lut_rd_s;
    end else begin
      pc_next_s = pc_r + PC_ONE;
    end
    wait_inc_s = wait_cnt_r + WAIT_ONE;
  end

  // Run-control FSM with PC, stall counter and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      pc_r          <= START_PC_V;
      wait_cnt_r    <= WAIT_ZERO;
      instr_valid_r <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      instr_valid_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start_ok_s) begin
            state_r       <= FETCH;
            pc_r          <= START_PC_V;
            instr_valid_r <= 1'b1;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
          end
        end
        FETCH: begin
          state_r <= EXEC;
        end
        EXEC: begin
          if (halt) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else if (mem_req) begin
            state_r    <= MEM_WAIT;
            wait_cnt_r <= WAIT_ZERO;
          end else begin
            state_r       <= FETCH;
            pc_r          <= pc_next_s;
            instr_valid_r <= 1'b1;
          end
        end
        MEM_WAIT: begin
          // An ack arriving on the last allowed cycle still commits
          if (commit_s) begin
            state_r       <= FETCH;
            pc_r          <= pc_next_s;
            instr_valid_r <= 1'b1;
          end else if (wait_inc_s == WAIT_LIMIT) begin
            state_r    <= DONE;
            wait_cnt_r <= wait_inc_s;
            done_r     <= 1'b1;
            err_r      <= 1'b1;
          end else begin
            wait_cnt_r <= wait_inc_s;
          end
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_CYCLE_CNT_EN
  logic [SEQ_CNT_W-1:0] cyc_cnt_r;
  logic                 running_s;

  assign running_s = (state_r == FETCH) || (state_r == EXEC) || (state_r == MEM_WAIT);

  // Count active cycles from start to done, saturating and frozen once done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt_r <= {SEQ_CNT_W{1'b0}};
    end else if (start_ok_s) begin
      cyc_cnt_r <= {SEQ_CNT_W{1'b0}};
    end else if (running_s && (cyc_cnt_r != {SEQ_CNT_W{1'b1}})) begin
      cyc_cnt_r <= cyc_cnt_r + {{(SEQ_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cyc_cnt_r <= cyc_cnt_r;
    end
  end

  assign cycle_count = cyc_cnt_r;
`else
  assign cycle_count = {SEQ_CNT_W{1'b0}};
`endif

  assign pc          = pc_r;
  assign instr_valid = instr_valid_r;
  assign exec_en     = commit_s;
  assign done        = done_r;
  assign err         = err_r;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: instruction-level model driven from a
// directed vector table, hand-written corner sequences and random programs.
module tb_program_sequencer;

  localparam int PC_W     = 10;
  localparam int LUT_W    = 5;
  localparam int MAX_WAIT = 15;
  localparam int K_PLAIN  = 0;
  localparam int K_BR     = 1;
  localparam int K_MEM    = 2;
  localparam int K_HALT   = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0, halt = 1'b0, br_en = 1'b0;
  logic             mem_req = 1'b0, mem_ack = 1'b0, lut_wr_en = 1'b0;
  logic [LUT_W-1:0] br_idx = '0, lut_wr_idx = '0;
  logic [PC_W-1:0]  lut_wr_data = '0;
  logic [PC_W-1:0]  pc;
  logic             instr_valid, exec_en, done, err;
  logic [15:0]      cycle_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              kind;
    bit              br;
    int              idx;
    int              nwait;   // no-ack cycles before ack; MAX_WAIT means never acked
    logic [PC_W-1:0] nxt;
    bit              err;
    bit              noise;   // pulse start / LUT writes while running
  } vec_t;

  logic [PC_W-1:0] lut_m [0:31];
  logic [PC_W-1:0] exp_pc;
  int              exp_cc;
  vec_t            tbl [0:8];

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt        (halt),
    .br_en       (br_en),
    .br_idx      (br_idx),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_idx  (lut_wr_idx),
    .lut_wr_data (lut_wr_data),
    .pc          (pc),
    .instr_valid (instr_valid),
    .exec_en     (exec_en),
    .done        (done),
    .err         (err),
    .cycle_count (cycle_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] cc_exp(input int n);
`ifdef SEQ_CYCLE_CNT_EN
    return (n > 65535) ? 32'hFFFF : n;
`else
    return 32'h0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start = 1'b0; halt = 1'b0; br_en = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; lut_wr_en = 1'b0;
  endtask

  task automatic lut_write(input int idx, input logic [PC_W-1:0] data);
    clr();
    lut_wr_en = 1'b1; lut_wr_idx = LUT_W'(idx); lut_wr_data = data;
    step();
    lut_wr_en = 1'b0;
    lut_m[idx] = data;
  endtask

  task automatic do_start();
    clr();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_pc = '0;
    exp_cc = 0;
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err, 0);
  endtask

  // One instruction from its FETCH cycle to the next FETCH (or DONE)
  task automatic do_instr(input vec_t v);
    bit ack;
    clr();
    chk("fetch_valid", instr_valid, 1);
    chk("fetch_pc", pc, exp_pc);
    chk("fetch_cc", cycle_count, cc_exp(exp_cc));
    if (v.noise) begin
      start = 1'($urandom_range(1, 0));
      lut_wr_en = 1'b1; lut_wr_idx = LUT_W'(v.idx); lut_wr_data = PC_W'($urandom);
    end
    #1 chk("fetch_exec_en", exec_en, 0);
    step(); exp_cc++;

    clr();
    chk("exec_valid", instr_valid, 0);
    chk("exec_pc", pc, exp_pc);
    br_en = v.br; br_idx = LUT_W'(v.idx);
    if (v.kind == K_HALT) begin
      halt = 1'b1; mem_req = 1'b1;
    end else if (v.kind == K_MEM) begin
      mem_req = 1'b1;
    end
    if (v.noise) start = 1'b1;
    #1 chk("exec_exec_en", exec_en, (v.kind == K_PLAIN || v.kind == K_BR) ? 1 : 0);
    step(); exp_cc++;

    if (v.kind == K_MEM) begin
      for (int k = 1; k <= MAX_WAIT; k++) begin
        ack = (k == v.nwait + 1);
        clr();
        br_en = v.br; mem_req = 1'b1; mem_ack = ack;
        chk("wait_valid", instr_valid, 0);
        chk("wait_pc", pc, exp_pc);
        chk("wait_done", done, 0);
        #1 chk("wait_exec_en", exec_en, ack);
        step(); exp_cc++;
        if (ack) break;
      end
    end

    clr();
    if (v.kind == K_HALT || v.err) begin
      chk("done_flag", done, 1);
      chk("done_err", err, v.err);
      chk("done_pc", pc, exp_pc);
      chk("done_valid", instr_valid, 0);
      chk("done_cc", cycle_count, cc_exp(exp_cc));
      #1 chk("done_exec_en", exec_en, 0);
    end else begin
      chk("run_done", done, 0);
      exp_pc = v.nxt;
    end
  endtask

  function automatic vec_t mk_rand(input logic [PC_W-1:0] cur);
    vec_t v;
    v.kind  = $urandom_range(K_MEM, K_PLAIN);
    v.idx   = $urandom_range(31, 0);
    v.br    = (v.kind == K_BR) ? 1'b1 : (v.kind == K_MEM) ? 1'($urandom_range(1, 0)) : 1'b0;
    v.nwait = (v.kind == K_MEM) ? $urandom_range(MAX_WAIT, 0) : 0;
    v.err   = (v.kind == K_MEM) && (v.nwait >= MAX_WAIT);
    v.nxt   = v.br ? lut_m[v.idx] : PC_W'((int'(cur) + 1) % (1 << PC_W));
    v.noise = 1'($urandom_range(1, 0));
    return v;
  endfunction

  initial begin
    vec_t v;
    int   len;

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_exec_en", exec_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cc", cycle_count, 0);
    step();
    reset = 1'b1;
    step();
    chk("idle_valid", instr_valid, 0);

    for (int i = 0; i < 32; i++) lut_write(i, PC_W'($urandom));
    lut_write(4, 10'h123);
    lut_write(7, 10'h3FF);
    lut_write(9, 10'h005);

    // Three plain instructions then halt: done after 8 active cycles
    do_start();
    for (int i = 0; i < 3; i++)
      do_instr('{K_PLAIN, 1'b0, 0, 0, PC_W'(i + 1), 1'b0, 1'b0});
    do_instr('{K_HALT, 1'b0, 0, 0, 10'h000, 1'b0, 1'b0});
    chk("t2_pc", pc, 3);
    chk("t2_cc", cycle_count, cc_exp(8));
    step();
    chk("t2_done_held", done, 1);
    chk("t2_cc_frozen", cycle_count, cc_exp(8));

    // Directed vector table: branches, stalls, wrap, start/LUT noise, halt priority
    tbl[0] = '{K_PLAIN, 1'b0, 0,  0,  10'h001, 1'b0, 1'b0};
    tbl[1] = '{K_BR,    1'b1, 4,  0,  10'h123, 1'b0, 1'b1};
    tbl[2] = '{K_BR,    1'b1, 9,  0,  10'h005, 1'b0, 1'b0};
    tbl[3] = '{K_MEM,   1'b0, 0,  3,  10'h006, 1'b0, 1'b0};
    tbl[4] = '{K_MEM,   1'b0, 0,  14, 10'h007, 1'b0, 1'b0};
    tbl[5] = '{K_BR,    1'b1, 7,  0,  10'h3FF, 1'b0, 1'b0};
    tbl[6] = '{K_PLAIN, 1'b0, 4,  0,  10'h000, 1'b0, 1'b1};
    tbl[7] = '{K_MEM,   1'b1, 9,  2,  10'h005, 1'b0, 1'b0};
    tbl[8] = '{K_HALT,  1'b1, 4,  0,  10'h000, 1'b0, 1'b0};
    do_start();
    for (int i = 0; i < 9; i++) do_instr(tbl[i]);
    chk("tbl_halt_pc", pc, 5);

    // Stall timeout, then restart clears err
    do_start();
    do_instr('{K_PLAIN, 1'b0, 0, 0, 10'h001, 1'b0, 1'b0});
    do_instr('{K_MEM, 1'b0, 0, MAX_WAIT, 10'h000, 1'b1, 1'b0});
    chk("to_pc", pc, 1);
    do_start();
    chk("restart_pc", pc, 0);
    chk("restart_valid", instr_valid, 1);
    do_instr('{K_HALT, 1'b0, 0, 0, 10'h000, 1'b0, 1'b0});

    // Reset asserted mid-FETCH, then LUT contents survive
    do_start();
    do_instr('{K_PLAIN, 1'b0, 0, 0, 10'h001, 1'b0, 1'b0});
    do_instr('{K_PLAIN, 1'b0, 0, 0, 10'h002, 1'b0, 1'b0});
    chk("pre_rst_pc", pc, 2);
    #2 reset = 1'b0;
    #1;
    chk("midrst_pc", pc, 0);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_exec_en", exec_en, 0);
    chk("midrst_cc", cycle_count, 0);
    step();
    reset = 1'b1;
    step();
    do_start();
    do_instr('{K_BR, 1'b1, 4, 0, 10'h123, 1'b0, 1'b0});
    do_instr('{K_HALT, 1'b0, 0, 0, 10'h000, 1'b0, 1'b0});

    // Random programs against the instruction-level model
    for (int p = 0; p < 12; p++) begin
      do_start();
      len = $urandom_range(10, 1);
      for (int i = 0; i < len; i++) begin
        v = mk_rand(exp_pc);
        do_instr(v);
        if (v.err) break;
        if (i == len - 1) do_instr('{K_HALT, 1'b0, 0, 0, 10'h000, 1'b0, 1'b1});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
